// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU / multiply-divide unit:
// ALU control codes, ALUop classes, M-extension func3 values and FSM states.
`timescale 1ns/1ps
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] ALUOP_LS  = 2'b00;
    localparam logic [1:0] ALUOP_LUI = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_J   = 2'b11;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_e;

endpackage

// File: rtl/md_iter_core.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide, one bit
// per step, sharing one 2*XLEN accumulator ({hi,lo} = product or {rem,quot}).
`timescale 1ns/1ps
module md_iter_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   mag_a_i,
    input  logic [XLEN-1:0]   mag_b_i,
    output logic              last_o,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shl_rem;
    logic [XLEN:0]     sub_diff;

    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        shl_rem  = acc_q[2*XLEN-1:XLEN-1];
        sub_diff = shl_rem - {1'b0, b_q};
        acc_d    = acc_q;
        b_d      = b_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        if (kill_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            acc_d = {{XLEN{1'b0}}, mag_a_i};
            b_d   = mag_b_i;
            div_d = is_div_i;
            cnt_d = CNT_W'(XLEN);
        end else if (step_i) begin
            cnt_d = cnt_q - 1'b1;
            // A clear borrow bit means the shifted remainder covered the divisor.
            if (div_q) begin
                if (!sub_diff[XLEN])
                    acc_d = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                else
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end else begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with RV32M multiply/divide behind a valid/ready handshake.
// Define FAST_MUL_EN for a single-cycle combinational multiplier.
`timescale 1ns/1ps
module alu_md_unit
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      func3,
    input  logic            func7,
    input  logic            m_bit,
    input  logic            op_r,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output state_e          dbg_state
);

    // Handshake: an op is taken on a clk edge where in_valid && in_ready;
    // out_valid is a one-cycle pulse with result stable from then on.
    localparam int SH_W = $clog2(XLEN);

    state_e            state_q;
    logic              out_valid_q, busy_q, neg_q;
    logic [XLEN-1:0]   result_q;
    logic [2:0]        f3_q;

    logic [3:0]        alu_ctrl;
    logic [XLEN-1:0]   alu_res;
    logic [SH_W-1:0]   shamt;
    logic              accept, is_m, sgn_a, sgn_b, neg_in;
    logic              div_zero, div_ovf, special, fast_go;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [2*XLEN-1:0] fast_prod, core_acc;
    logic              core_start, core_step, core_last;

`ifdef FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    assign fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`else
    localparam bit FAST_MUL = 1'b0;
    assign fast_prod = '0;
`endif

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_LUI: alu_ctrl = ALU_PASSB;
            ALUOP_RI: begin
                case (func3)
                    3'b000:  alu_ctrl = (func7 && op_r) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = func7 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    assign shamt = op_b[SH_W-1:0];

    always_comb begin
        case (alu_ctrl)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:  alu_res = op_b;
        endcase
    end

    // Sign handling: the core works on magnitudes, FIX negates as required.
    always_comb begin
        is_m   = (alu_op == ALUOP_RI) && op_r && m_bit;
        sgn_a  = op_a[XLEN-1] && (func3 == F3_MULH || func3 == F3_MULHSU ||
                                  func3 == F3_DIV  || func3 == F3_REM);
        sgn_b  = op_b[XLEN-1] && (func3 == F3_MULH || func3 == F3_DIV ||
                                  func3 == F3_REM);
        mag_a  = sgn_a ? -op_a : op_a;
        mag_b  = sgn_b ? -op_b : op_b;
        neg_in = (func3 == F3_REM) ? sgn_a : (sgn_a ^ sgn_b);
        div_zero = (op_b == '0);
        div_ovf  = (func3 == F3_DIV || func3 == F3_REM) &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
        special  = func3[2] && (div_zero || div_ovf);
        if (div_zero)
            special_res = func3[1] ? op_a : '1;
        else
            special_res = func3[1] ? '0 : op_a;
        fast_go = FAST_MUL && !func3[2];
    end

    function automatic logic [XLEN-1:0] md_pick(input logic [2:0] f3, input logic neg,
                                                 input logic [2*XLEN-1:0] mag);
        logic [2*XLEN-1:0] full;
        logic [XLEN-1:0]   half;
        if (f3[2]) begin
            half    = f3[1] ? mag[2*XLEN-1:XLEN] : mag[XLEN-1:0];
            md_pick = neg ? -half : half;
        end else begin
            full    = neg ? -mag : mag;
            md_pick = (f3 == F3_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
        end
    endfunction

    assign accept     = in_valid && in_ready;
    assign core_start = accept && !flush && is_m && !special && !fast_go;
    assign core_step  = (state_q == MUL || state_q == DIV) && !flush;

    md_iter_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .start_i  (core_start),
        .kill_i   (flush),
        .step_i   (core_step),
        .is_div_i (func3[2]),
        .mag_a_i  (mag_a),
        .mag_b_i  (mag_b),
        .last_o   (core_last),
        .acc_o    (core_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            f3_q        <= '0;
            neg_q       <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!is_m) begin
                            result_q    <= alu_res;
                            out_valid_q <= 1'b1;
                        end else if (special) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                        end else if (fast_go) begin
                            result_q    <= md_pick(func3, neg_in, fast_prod);
                            out_valid_q <= 1'b1;
                        end else begin
                            f3_q    <= func3;
                            neg_q   <= neg_in;
                            busy_q  <= 1'b1;
                            state_q <= func3[2] ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (core_last)
                        state_q <= FIX;
                end
                FIX: begin
                    result_q    <= md_pick(f3_q, neg_q, core_acc);
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = !busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: ALU decode, M-ops with latency, special
// cases, flush and mid-op reset. Honours FAST_MUL_EN for multiply latency.
`timescale 1ns/1ps
module tb_alu_md_unit;
    import alu_pkg::*;

    localparam int XLEN = 32;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic            clk = 1'b0;
    logic            rst, in_valid, flush, func7, m_bit, op_r;
    logic            in_ready, out_valid, busy;
    logic [1:0]      alu_op;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a, op_b, result;
    state_e          dbg_state;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [31:0]     last_exp = '0;

    alu_md_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .alu_op    (alu_op),
        .func3     (func3),
        .func7     (func7),
        .m_bit     (m_bit),
        .op_r      (op_r),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .result    (result),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                          input logic m, input logic r, input logic [31:0] a, input logic [31:0] b);
        alu_op = aop; func3 = f3; func7 = f7; m_bit = m; op_r = r; op_a = a; op_b = b;
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic f7, input logic m, input logic r,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit disturb);
        int cyc;
        set_op(aop, f3, f7, m, r, a, b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        check_eq({tag, "/busy"}, 32'(busy), 32'(exp_lat > 1));
        while (!out_valid && cyc < 200) begin
            if (disturb && cyc < 4) begin
                in_valid = 1'b1;
                set_op(ALUOP_RI, 3'b000, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check_eq({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, "/result"}, result, exp);
        last_exp = exp;
        tick();
        check_eq({tag, "/pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) tick();
        check_eq("rst/in_ready", 32'(in_ready), 32'd1);
        check_eq("rst/out_valid", 32'(out_valid), 32'd0);
        check_eq("rst/result", result, 32'd0);
        check_eq("rst/busy", 32'(busy), 32'd0);
        check_eq("rst/state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // Single-cycle ALU decode
        run_op("sub",   ALUOP_RI,  3'b000, 1, 0, 1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0);
        run_op("addi",  ALUOP_RI,  3'b000, 1, 0, 0, 32'd5, 32'd7, 32'd12, 1, 0);
        run_op("sra",   ALUOP_RI,  3'b101, 1, 0, 0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 0);
        run_op("srl",   ALUOP_RI,  3'b101, 0, 0, 0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, 0);
        run_op("sll",   ALUOP_RI,  3'b001, 0, 0, 1, 32'd1, 32'h0000_003F, 32'h8000_0000, 1, 0);
        run_op("slt",   ALUOP_RI,  3'b010, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
        run_op("sltu",  ALUOP_RI,  3'b011, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        run_op("xor",   ALUOP_RI,  3'b100, 0, 0, 1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1, 0);
        run_op("or",    ALUOP_RI,  3'b110, 0, 0, 1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1, 0);
        run_op("and",   ALUOP_RI,  3'b111, 0, 0, 1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, 0);
        run_op("ls",    ALUOP_LS,  3'b111, 1, 0, 1, 32'h10, 32'h20, 32'h30, 1, 0);
        run_op("lui",   ALUOP_LUI, 3'b000, 0, 0, 0, 32'h1, 32'h1234_5000, 32'h1234_5000, 1, 0);
        run_op("jump",  ALUOP_J,   3'b000, 1, 0, 1, 32'h100, 32'h4, 32'h104, 1, 0);

        // Multiply family
        run_op("mulh",   ALUOP_RI, F3_MULH,   0, 1, 1, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, MUL_LAT, 1);
        run_op("mul",    ALUOP_RI, F3_MUL,    0, 1, 1, 32'd6, 32'd7, 32'd42, MUL_LAT, 0);
        run_op("mulneg", ALUOP_RI, F3_MUL,    0, 1, 1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, MUL_LAT, 0);
        run_op("mulhu",  ALUOP_RI, F3_MULHU,  0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
        run_op("mulhsu", ALUOP_RI, F3_MULHSU, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);

        // Divide family and special cases
        run_op("div",     ALUOP_RI, F3_DIV,  0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 1);
        run_op("rem",     ALUOP_RI, F3_REM,  0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, 0);
        run_op("divu",    ALUOP_RI, F3_DIVU, 0, 1, 1, 32'd100, 32'd7, 32'd14, DIV_LAT, 0);
        run_op("remu",    ALUOP_RI, F3_REMU, 0, 1, 1, 32'd100, 32'd7, 32'd2, DIV_LAT, 0);
        run_op("divu0",   ALUOP_RI, F3_DIVU, 0, 1, 1, 32'd55, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem0",    ALUOP_RI, F3_REM,  0, 1, 1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 1, 0);
        run_op("divovf",  ALUOP_RI, F3_DIV,  0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("removf",  ALUOP_RI, F3_REM,  0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Flush ten cycles into a divide
        set_op(ALUOP_RI, F3_DIVU, 1'b0, 1'b1, 1'b1, 32'd1000, 32'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush/busy", 32'(busy), 32'd0);
        check_eq("flush/out_valid", 32'(out_valid), 32'd0);
        check_eq("flush/state", 32'(dbg_state), 32'(IDLE));
        check_eq("flush/in_ready", 32'(in_ready), 32'd1);
        check_eq("flush/result_hold", result, last_exp);
        run_op("post_flush_add", ALUOP_RI, 3'b000, 0, 0, 1, 32'd3, 32'd4, 32'd7, 1, 0);
        watch_quiet("flush/no_stray", 40);

        // Flush coincident with accept discards the op
        set_op(ALUOP_RI, 3'b000, 1'b0, 1'b0, 1'b1, 32'd9, 32'd9);
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        check_eq("flush_acc/out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_acc/result", result, last_exp);
        check_eq("flush_acc/busy", 32'(busy), 32'd0);

        // Reset five cycles into a multiply
        set_op(ALUOP_RI, F3_MUL, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check_eq("midrst/in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst/out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst/result", result, 32'd0);
        check_eq("midrst/busy", 32'(busy), 32'd0);
        check_eq("midrst/state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        watch_quiet("midrst/no_stray", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Parametrised execute-stage unit, successor to the 2-bit ALUop control decoder.
- Decodes ALUop/func3/func7 into the 4-bit ALU control code and executes the op internally.
- Adds RV32M multiply/divide as an iterative multi-cycle datapath behind a valid/ready handshake.
- Drives `busy` so the hazard unit can stall IF/ID/EX while a long op runs.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and a power of two.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX has an op this cycle
- in_ready  out  1  unit accepts an op this cycle
- flush  in  1  kill the in-flight op (branch mispredict)
- alu_op  in  2  00 load/store, 01 lui, 10 R/I-type, 11 jump
- func3  in  3  instr[14:12]
- func7  in  1  instr[30]
- m_bit  in  1  instr[25]; selects M-extension when op_r=1
- op_r  in  1  1 = R-type (opcode bit 5)
- op_a  in  XLEN  rs1 operand
- op_b  in  XLEN  rs2/immediate operand
- out_valid  out  1  one-cycle pulse: result valid
- result  out  XLEN  registered result
- busy  out  1  multi-cycle op in progress

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, busy=0, state=IDLE, counter=0.
- Accept on in_valid & in_ready.
- Control codes are unchanged from the current decoder:
  - 0000 and, 0001 or, 0010 add, 0011 sub, 0100 sll, 0101 srl, 0110 sra, 0111 xor, 1000 slt, 1001 sltu, 1111 pass op_b.
  - alu_op 00/11 → add; 01 → pass op_b.
  - alu_op 10 → decode by func3; sub only when func7=1 & op_r=1; func3=101 selects sra when func7=1.
- Shift amount is op_b[$clog2(XLEN)-1:0].
- M-op when alu_op=10 & op_r=1 & m_bit=1; func3 selects:
  - mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- State machine:
  - IDLE: a non-M op is accepted → result registered, out_valid=1 next cycle, stay IDLE. Back-to-back throughput is 1 per cycle.
  - IDLE: an M-op is accepted (non-special) → go to MUL or DIV; load counter=XLEN; busy=1; in_ready=0.
  - MUL: shift-add on operand magnitudes with a 2·XLEN accumulator, one bit per cycle.
  - DIV: restoring shift-subtract on magnitudes, one quotient bit per cycle.
  - Counter reaching 0 → go to FIX.
  - FIX: apply sign correction (two's complement negate), select low/high half or quotient/remainder, register result; out_valid=1 next cycle; return to IDLE; busy falls in the same cycle out_valid rises.
- M-op latency: XLEN+2 cycles from accept to out_valid (34 for XLEN=32).
- Signedness rules:
  - mulh: both operands signed.
  - mulhsu: op_a signed, op_b unsigned.
  - div/rem: quotient sign = sign_a ^ sign_b; remainder sign = sign_a.
- Special cases complete in 1 cycle (no iteration), out_valid the next cycle:
  - Divide by zero: div/divu → all-ones; rem/remu → op_a.
  - Signed overflow (op_a = most-negative, op_b = −1): div → op_a; rem → 0.
- Operands are latched at accept; the input bus may change while busy.
- flush: any state returns to IDLE next cycle, out_valid=0, busy=0, result holds its last value.
- flush coincident with accept: the op is discarded.
- rst has priority over flush.
- rst mid-operation: full reset, no out_valid.
- in_valid while busy is ignored; EX stalls via busy.

Optional Feature:
- FAST_MUL_EN defined: multiplies use a single-cycle XLEN×XLEN combinational multiplier; out_valid the cycle after accept; MUL state is unused; busy is never set for multiplies.
- Undefined: iterative multiply as above. Divide is always iterative.

Decomposition:
- Package alu_pkg holds:
  - ALU control code localparams (ALU_AND … ALU_PASSB);
  - alu_op encodings (ALUOP_LS, ALUOP_LUI, ALUOP_RI, ALUOP_J);
  - M func3 localparams;
  - state encoding (IDLE, MUL, DIV, FIX).
- One sub-module: md_iter_core (magnitude shift-add/shift-subtract datapath plus counter).
- Decode and the single-cycle ALU stay in the top.

Test Plan:
- alu_op=10, op_r=1, func7=1, func3=000, a=5, b=7 → one cycle later out_valid=1, result=0xFFFFFFFE; the same decode with op_r=0 gives 12.
- func3=101, func7=1, a=0x80000000, b=4 → 0xF8000000; func7=0 → 0x08000000.
- mulh, a=0x80000000, b=2 → busy for 33 cycles, out_valid at cycle 34, result=0xFFFFFFFF; with FAST_MUL_EN, out_valid at cycle 1.
- div, a=−7, b=2 → −3 (0xFFFFFFFD); rem → −1; divu with b=0 → 0xFFFFFFFF in 1 cycle; div 0x80000000/−1 → 0x80000000.
- Accept divu, then assert flush at cycle 10 → IDLE next cycle, no out_valid; a new add is accepted immediately and returns its result.
- rst asserted at cycle 5 of a mul → all outputs at reset values next cycle, in_ready=1.
